rect_fill_writer: RTL and testbench
===================================

// Module: rect_fill_writer
// PURPOSE
//  Write-side counterpart of the rectangle hit-test logic: paints a solid X-by-Y box of one
//  colour into the 640-wide, row-major VGA framebuffer, origin at linear pixel address startaddr.
//  Sits between game logic (arena clear, bike/trail blocks, banners) and the framebuffer RAM
//  write port, which may stall it through a valid/ready handshake.
// PARAMETERS
//  SCREEN_W  640     pixels per row; row stride added per line
//  SCREEN_PX 307200  total pixels (640*480); addresses >= this are off-screen
//  ADDR_W    19      framebuffer address width
//  DIM_W     10      width of X and Y
//  COLOR_W   8       pixel data width
// PORTS
//  clock      in  1        system clock, all state on rising edge
//  reset      in  1        synchronous, active-high
//  start      in  1        request fill; sampled only in IDLE
//  startaddr  in  ADDR_W   top-left pixel address; latched on accepted start
//  X          in  DIM_W    box width in pixels; latched on accepted start
//  Y          in  DIM_W    box height in rows; latched on accepted start
//  color      in  COLOR_W  fill value; latched on accepted start
//  outline    in  1        outline-only mode (present only with RECT_FILL_OUTLINE_EN)
//  busy       out 1        high from cycle after accepted start until done pulse, inclusive
//  done       out 1        one-cycle pulse when fill completes
//  wr_en      out 1        write valid to framebuffer
//  wr_addr    out ADDR_W   write address
//  wr_data    out COLOR_W  write data (= latched color)
//  wr_ready   in  1        framebuffer accepts write when wr_en & wr_ready at clock edge
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, wr_en = 0; wr_addr, wr_data = 0; counters cleared.
//  - States: IDLE -> FILL -> DONE -> IDLE.
//  - IDLE: start=1 latches inputs. X==0 or Y==0 -> DONE directly (no writes); else FILL.
//  - FILL: visits col 0..X-1 within row 0..Y-1, row-major; pixel addr =
//    row_base + col, row_base = startaddr + row*SCREEN_W, updated incrementally (no multiplier).
//  - First wr_en asserted the cycle after start accepted (latency 1).
//  - While wr_en=1 and wr_ready=0: wr_addr, wr_data, wr_en held stable; counters frozen.
//  - Beat advances on wr_en & wr_ready. Off-screen pixel (addr >= SCREEN_PX): wr_en=0 that
//    cycle, beat advances unconditionally (1 cycle per skipped pixel, no stall).
//  - Address arithmetic ADDR_W+1 bits internally; never wraps to low addresses.
//  - After last pixel beat (col X-1, row Y-1) -> DONE: done=1, busy=1 for one cycle -> IDLE.
//  - Throughput with wr_ready=1: X*Y beats; done in cycle after last beat.
//  - start while busy ignored; inputs changing during FILL have no effect.
//  - reset mid-fill: next edge returns to IDLE with all outputs at reset values; no done.
// CONFIGURATION
//  RECT_FILL_OUTLINE_EN defined: outline port present, latched on start. outline=1 -> only
//   row 0, row Y-1, col 0, col X-1 written; interior pixels skipped, 1 cycle each, wr_en=0.
//   outline=0 -> solid fill, identical to macro-absent behaviour.
//  Undefined: no outline port; always solid fill.
// TESTING
//  1 X=3,Y=2,startaddr=100,color=8'h1C,wr_ready=1 -> wr_addr 100,101,102,740,741,742 on 6
//    consecutive cycles starting 1 cycle after start; done pulse in the 7th cycle.
//  2 X=0,Y=5 -> no wr_en; done 1 cycle after start; busy high only that cycle.
//  3 Case 1 with wr_ready=0 for 3 cycles while wr_addr=101 -> 101 held 4 cycles, wr_data
//    stable, sequence and final addr unchanged; done delayed by 3 cycles.
//  4 startaddr=307198,X=4,Y=1 -> writes 307198,307199 only; 2 skip cycles; done after 4 beats.
//  5 RECT_FILL_OUTLINE_EN, outline=1,X=3,Y=3,startaddr=0 -> writes 0,1,2,640,642,1280,1281,1282;
//    addr 641 never written; done after 9 beats.
//  6 reset asserted during 3rd beat of case 1 -> next cycle wr_en=0,busy=0, no done;
//    subsequent start runs case 1 cleanly from addr 100.

Source files
------------

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: paints an X-by-Y box of one colour into a 640-wide row-major framebuffer.
// Latency: first write request one cycle after an accepted start; one beat per cycle when ready.
// Backpressure: wr_en & !wr_ready freezes address, data and counters until the write is taken.
//
// Ports:
//   i_clock, i_reset        clock; synchronous active-high reset
//   i_start                 fill request, only sampled while idle
//   i_startaddr, i_x, i_y   top-left linear address, box width, box height (latched on start)
//   i_color                 fill value (latched on start)
//   i_outline               outline-only mode, present only when RECT_FILL_OUTLINE_EN is defined
//   o_busy, o_done          busy from the cycle after start through the done pulse; done is 1 cycle
//   o_wr_en, o_wr_addr,
//   o_wr_data, i_wr_ready   framebuffer write port with valid/ready handshake
//
// Build option: define RECT_FILL_OUTLINE_EN to add the outline port and outline-only painting.
module rect_fill_writer #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_PX = 307200,
    parameter int ADDR_W    = 19,
    parameter int DIM_W     = 10,
    parameter int COLOR_W   = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_startaddr,
    input  logic [DIM_W-1:0]   i_x,
    input  logic [DIM_W-1:0]   i_y,
    input  logic [COLOR_W-1:0] i_color,
`ifdef RECT_FILL_OUTLINE_EN
    input  logic               i_outline,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [COLOR_W-1:0] o_wr_data,
    input  logic               i_wr_ready
);

    // One extra bit so row_base + col can exceed the screen without wrapping.
    localparam int AW1 = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [AW1-1:0]     r_row_base;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [DIM_W-1:0]   r_x;
    logic [DIM_W-1:0]   r_y;
    logic [COLOR_W-1:0] r_color;

    logic [AW1-1:0]     w_addr;
    logic               w_onscreen;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_paint;
    logic               w_beat;
    logic               w_accept;

    assign w_addr     = r_row_base + {{(AW1-DIM_W){1'b0}}, r_col};
    assign w_onscreen = (w_addr < AW1'(SCREEN_PX));
    assign w_col_last = (r_col == (r_x - DIM_W'(1)));
    assign w_row_last = (r_row == (r_y - DIM_W'(1)));
    assign w_accept   = (r_state == S_IDLE) && i_start;

`ifdef RECT_FILL_OUTLINE_EN
    logic r_outline;
    logic w_edge;

    assign w_edge  = (r_row == '0) || w_row_last || (r_col == '0) || w_col_last;
    // Interior pixels in outline mode are walked like off-screen ones: no write, no stall.
    assign w_paint = w_onscreen && (!r_outline || w_edge);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_outline <= 1'b0;
        end else if (w_accept) begin
            r_outline <= i_outline;
        end
    end
`else
    assign w_paint = w_onscreen;
`endif

    // Skipped pixels advance unconditionally; painted pixels wait for the handshake.
    assign w_beat = (r_state == S_FILL) && (!w_paint || i_wr_ready);

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = ((i_x == '0) || (i_y == '0)) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_beat && w_col_last && w_row_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        o_busy    = (r_state != S_IDLE);
        o_done    = (r_state == S_DONE);
        o_wr_en   = (r_state == S_FILL) && w_paint;
        o_wr_addr = w_addr[ADDR_W-1:0];
        o_wr_data = r_color;
    end

    // Walk counters and latched request.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
        end else if (w_accept) begin
            r_row_base <= {1'b0, i_startaddr};
            r_col      <= '0;
            r_row      <= '0;
            r_x        <= i_x;
            r_y        <= i_y;
            r_color    <= i_color;
        end else if (w_beat) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + DIM_W'(1);
                // Once a row starts off-screen every later row does too, so stop
                // adding the stride; this keeps the sum inside AW1 bits.
                if (r_row_base < AW1'(SCREEN_PX)) begin
                    r_row_base <= r_row_base + AW1'(SCREEN_W);
                end
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// tb_rect_fill_writer: scoreboard bench for rect_fill_writer with directed and random boxes.
// Latency: expected writes are queued at stimulus time, popped by a negedge monitor.
// Backpressure: wr_ready is driven always-high, random, or stalled on a chosen address.
module tb_rect_fill_writer;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_PX = 307200;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [18:0] sa;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  color;
`ifdef RECT_FILL_OUTLINE_EN
    logic        outline;
`endif
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;

    wr_t exp_q[$];
    int  n_chk      = 0;
    int  n_pass     = 0;
    int  exp_done   = 0;
    int  done_seen  = 0;
    bit  rdy_rand   = 0;
    int  stall_addr = -1;
    int  stall_len  = 0;
    int  stall_cnt  = 0;
    bit  prev_stall = 0;
    int  p_addr     = 0;
    int  p_data     = 0;

    rect_fill_writer dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_startaddr (sa),
        .i_x         (x),
        .i_y         (y),
        .i_color     (color),
`ifdef RECT_FILL_OUTLINE_EN
        .i_outline   (outline),
`endif
        .o_busy      (busy),
        .o_done      (done),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_wr_ready  (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every pixel of the box in row-major order, keeping only on-screen
    // ones (and, in outline mode, only border ones).
    task automatic model(input int s, input int w, input int h, input int c, input int outl);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                int  a;
                bit  border;
                a      = s + r * SCREEN_W + k;
                border = (r == 0) || (r == h - 1) || (k == 0) || (k == w - 1);
                if (a < SCREEN_PX && (outl == 0 || border)) begin
                    exp_q.push_back('{a, c});
                end
            end
        end
    endtask

    // Ready generator: random, or stall a given address for stall_len cycles.
    initial wr_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rdy_rand) begin
            wr_ready = ($urandom_range(0, 3) != 0);
        end else if (wr_en && int'(wr_addr) == stall_addr && stall_cnt < stall_len) begin
            wr_ready = 1'b0;
            stall_cnt++;
        end else begin
            wr_ready = 1'b1;
            if (!(wr_en && int'(wr_addr) == stall_addr)) stall_cnt = 0;
        end
    end

    // Monitor: pops one expected write per accepted beat, checks stall stability and done.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_hold", (wr_en && int'(wr_addr) == p_addr && int'(wr_data) == p_data), 1);
        end
        if (wr_en && wr_ready) begin
            chk("sb_has_entry", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
            end
        end
        if (done) begin
            done_seen++;
            chk("done_sb_empty", exp_q.size(), 0);
            chk("done_busy", busy, 1);
        end
        prev_stall = wr_en && !wr_ready && !rst;
        p_addr     = int'(wr_addr);
        p_data     = int'(wr_data);
        // A synchronous reset at the coming edge abandons whatever is left.
        if (rst) exp_q.delete();
    end

    // Issue one fill and wait for done. exp_k >= 0 demands done exactly exp_k
    // negedges after the accepting edge.
    task automatic run_fill(input int s, input int w, input int h, input int c,
                            input int outl, input bit rnd, input int exp_k);
        int  n;
        bit  got;
        int  bound;
        model(s, w, h, c, outl);
        exp_done++;
        @(posedge clk); #1;
        sa    = 19'(s);
        x     = 10'(w);
        y     = 10'(h);
        color = 8'(c);
`ifdef RECT_FILL_OUTLINE_EN
        outline = outl[0];
`endif
        start    = 1'b1;
        rdy_rand = rnd;
        @(posedge clk); #1;
        // Scramble inputs and keep poking start: none of it may matter now.
        sa    = 19'($urandom_range(0, 524287));
        x     = 10'($urandom);
        y     = 10'($urandom);
        color = 8'($urandom);
        start = 1'($urandom);
        n     = 0;
        got   = 0;
        bound = 8 * w * h + 20;
        while (n < bound && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        chk("done_seen_in_bound", got, 1);
        if (exp_k >= 0) chk("done_cycle", n, exp_k);
        @(posedge clk); #1;
        start    = 1'b0;
        rdy_rand = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_wr_en", wr_en, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sa    = '0;
        x     = '0;
        y     = '0;
        color = '0;
`ifdef RECT_FILL_OUTLINE_EN
        outline = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 3x2 box, full rate: done 7 cycles after acceptance.
        run_fill(100, 3, 2, 'h1C, 0, 0, 7);
        // Empty box: done straight away, no writes.
        run_fill(500, 0, 5, 'h33, 0, 0, 1);
        // Stall address 101 for three cycles: done three cycles later.
        stall_addr = 101;
        stall_len  = 3;
        run_fill(100, 3, 2, 'h1C, 0, 0, 10);
        stall_addr = -1;
        // Box hanging off the end of the screen.
        run_fill(307198, 4, 1, 'h5A, 0, 0, 5);
`ifdef RECT_FILL_OUTLINE_EN
        run_fill(0, 3, 3, 'hE0, 1, 0, 10);
`endif

        // Reset during the third beat: no done, outputs back to reset values.
        model(100, 3, 2, 'h1C, 0);
        @(posedge clk); #1;
        sa    = 19'd100;
        x     = 10'd3;
        y     = 10'd2;
        color = 8'h1C;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        run_fill(100, 3, 2, 'h1C, 0, 0, 7);

        // Random boxes around the screen, half with random backpressure.
        for (int i = 0; i < 40; i++) begin
            int  s;
            int  w;
            int  h;
            int  m;
            int  o;
            bit  rr;
            m = $urandom_range(0, 2);
            if (m == 0)      s = $urandom_range(0, SCREEN_PX - 1);
            else if (m == 1) s = SCREEN_PX - $urandom_range(1, 2000);
            else             s = $urandom_range(SCREEN_PX, 524287);
            w  = $urandom_range(0, 12);
            h  = $urandom_range(0, 12);
            rr = 1'($urandom);
`ifdef RECT_FILL_OUTLINE_EN
            o = $urandom_range(0, 1);
`else
            o = 0;
`endif
            if (rr) run_fill(s, w, h, $urandom_range(0, 255), o, 1, -1);
            else    run_fill(s, w, h, $urandom_range(0, 255), o, 0, (w * h == 0) ? 1 : w * h + 1);
        end

        repeat (4) @(negedge clk);
        chk("done_count", done_seen, exp_done);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
